// File: rtl/player_motion_ctrl_pkg.sv
// Shared constants, types and helpers for the balance-board ball motion sequencer.
// The renderer derives its circle test from the same RADIUS via RADIUS_SQUARE.
package player_motion_ctrl_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int RADIUS         = 16;
  localparam int RADIUS_SQUARE  = RADIUS * RADIUS;
  localparam int HOME_X         = 320;
  localparam int HOME_Y         = 240;
  localparam int TILT_SHIFT     = 2;
  localparam int FRICTION_SHIFT = 4;
  localparam int VMAX           = 64;
  localparam int X_LIMIT        = H_ACTIVE - 1 - RADIUS;
  localparam int Y_LIMIT        = V_ACTIVE - 1 - RADIUS;

  typedef logic signed [7:0] q44_t;   // signed Q4.4 px/frame
  typedef logic [13:0]       pos_q_t; // unsigned Q10.4 px

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_VEL,
    S_POS,
    S_COLLIDE,
    S_COMMIT
  } state_t;

  // Arithmetic right shift that rounds toward zero instead of toward -inf.
  function automatic logic signed [9:0] trunc_shr(input logic signed [9:0] x, input int sh);
    logic signed [9:0] bias;
    bias = x[9] ? 10'((1 << sh) - 1) : 10'sd0;
    return (x + bias) >>> sh;
  endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Frame-control and published-motion signals between game logic and the motion sequencer.
interface player_motion_ctrl_if;
  import player_motion_ctrl_pkg::*;

  logic        frame_tick;
  logic        game_en;
  logic        restart;
  q44_t        tilt_x;
  q44_t        tilt_y;
  logic [10:0] position_x;
  logic [10:0] position_y;
  q44_t        vel_x;
  q44_t        vel_y;
  logic [3:0]  wall_hit;
  logic        update_done;
  logic        overrun;

  modport master (
    output frame_tick, game_en, restart, tilt_x, tilt_y,
    input  position_x, position_y, vel_x, vel_y, wall_hit, update_done, overrun
  );

  modport slave (
    input  frame_tick, game_en, restart, tilt_x, tilt_y,
    output position_x, position_y, vel_x, vel_y, wall_hit, update_done, overrun
  );
endinterface

// File: rtl/player_motion_ctrl_axis_step.sv
// Combinational per-axis motion step: velocity update, position integrate and wall resolve.
// Each stage reads the registered result of the previous one, so the FSM spaces them a cycle apart.
module player_motion_ctrl_axis_step
  import player_motion_ctrl_pkg::*;
#(
  parameter int LIMIT = X_LIMIT
) (
  input  q44_t               v,
  input  q44_t               tilt,
  input  q44_t               v_stage,
  input  pos_q_t             pos,
  input  logic signed [15:0] p_stage,
  output q44_t               v_vel,
  output logic signed [15:0] p_pos,
  output logic signed [15:0] p_col,
  output q44_t               v_col,
  output logic               hit_lo,
  output logic               hit_hi
);

  localparam logic signed [9:0]  VMAX_W  = 10'(VMAX);
  localparam logic signed [15:0] LO_Q    = 16'(RADIUS * 16);
  localparam logic signed [15:0] HI_Q    = 16'(LIMIT * 16);
  // First Q10.4 value whose integer part lies beyond the high wall.
  localparam logic signed [15:0] HI_TRIP = 16'((LIMIT + 1) * 16);

  logic signed [9:0] v_w, tilt_w, accel, drag, sum, sat, vs_w, bounce;

  // NOTE: every combinational output gets a default at the top of the block, so no path infers a latch.
  always_comb begin
    v_w    = {{2{v[7]}}, v};
    tilt_w = {{2{tilt[7]}}, tilt};
    accel  = tilt_w >>> TILT_SHIFT;
    drag   = trunc_shr(v_w, FRICTION_SHIFT);
    sum    = v_w + accel - drag;
    if (sum > VMAX_W)       sat = VMAX_W;
    else if (sum < -VMAX_W) sat = -VMAX_W;
    else                    sat = sum;
    v_vel  = sat[7:0];

    p_pos  = $signed({2'b00, pos}) + $signed({{8{v_stage[7]}}, v_stage});

    vs_w   = {{2{v_stage[7]}}, v_stage};
    bounce = -trunc_shr(vs_w, 1);
    p_col  = p_stage;
    v_col  = v_stage;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    // A negative position is also below LO_Q, so it resolves against the low wall.
    if (p_stage < LO_Q) begin
      p_col  = LO_Q;
      v_col  = bounce[7:0];
      hit_lo = 1'b1;
    end else if (p_stage >= HI_TRIP) begin
      p_col  = HI_Q;
      v_col  = bounce[7:0];
      hit_hi = 1'b1;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame ball motion sequencer: one tick in vblank runs SAMPLE..COMMIT and publishes the new
// centre only at COMMIT, so the renderer never sees a half-updated position.
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  player_motion_ctrl_if.slave bus
);

  state_t             state, state_nxt;
  pos_q_t             pos_x, pos_y;
  q44_t               v_x, v_y, tilt_xl, tilt_yl, vs_x, vs_y;
  logic signed [15:0] ps_x, ps_y;
  logic [3:0]         hit_s, wall_hit;
  logic               update_done, overrun;

  q44_t               v_vel_x, v_vel_y, v_col_x, v_col_y;
  logic signed [15:0] p_pos_x, p_pos_y, p_col_x, p_col_y;
  logic               hit_left, hit_right, hit_top, hit_bottom;

  player_motion_ctrl_axis_step #(.LIMIT(X_LIMIT)) u_axis_x (
    .v(v_x), .tilt(tilt_xl), .v_stage(vs_x), .pos(pos_x), .p_stage(ps_x),
    .v_vel(v_vel_x), .p_pos(p_pos_x), .p_col(p_col_x), .v_col(v_col_x),
    .hit_lo(hit_left), .hit_hi(hit_right)
  );

  player_motion_ctrl_axis_step #(.LIMIT(Y_LIMIT)) u_axis_y (
    .v(v_y), .tilt(tilt_yl), .v_stage(vs_y), .pos(pos_y), .p_stage(ps_y),
    .v_vel(v_vel_y), .p_pos(p_pos_y), .p_col(p_col_y), .v_col(v_col_y),
    .hit_lo(hit_top), .hit_hi(hit_bottom)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.frame_tick && bus.game_en) state_nxt = S_SAMPLE;
      S_SAMPLE:  state_nxt = S_VEL;
      S_VEL:     state_nxt = S_POS;
      S_POS:     state_nxt = S_COLLIDE;
      S_COLLIDE: state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (bus.restart) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x       <= pos_q_t'(HOME_X << 4);
      pos_y       <= pos_q_t'(HOME_Y << 4);
      v_x         <= '0;
      v_y         <= '0;
      tilt_xl     <= '0;
      tilt_yl     <= '0;
      vs_x        <= '0;
      vs_y        <= '0;
      ps_x        <= '0;
      ps_y        <= '0;
      hit_s       <= '0;
      wall_hit    <= '0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      update_done <= 1'b0;
      wall_hit    <= '0;
      if (bus.restart) begin
        pos_x   <= pos_q_t'(HOME_X << 4);
        pos_y   <= pos_q_t'(HOME_Y << 4);
        v_x     <= '0;
        v_y     <= '0;
        overrun <= 1'b0;
      end else begin
        // A tick during a running sequence is dropped, only flagged.
        if (bus.frame_tick && state != S_IDLE) overrun <= 1'b1;
        case (state)
          S_SAMPLE: begin
            tilt_xl <= bus.tilt_x;
            tilt_yl <= bus.tilt_y;
          end
          S_VEL: begin
            vs_x <= v_vel_x;
            vs_y <= v_vel_y;
          end
          S_POS: begin
            ps_x <= p_pos_x;
            ps_y <= p_pos_y;
          end
          S_COLLIDE: begin
            ps_x  <= p_col_x;
            ps_y  <= p_col_y;
            vs_x  <= v_col_x;
            vs_y  <= v_col_y;
            hit_s <= {hit_bottom, hit_top, hit_right, hit_left};
          end
          S_COMMIT: begin
            pos_x       <= ps_x[13:0];
            pos_y       <= ps_y[13:0];
            v_x         <= vs_x;
            v_y         <= vs_y;
            wall_hit    <= hit_s;
            update_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.position_x  = {1'b0, pos_x[13:4]};
  assign bus.position_y  = {1'b0, pos_y[13:4]};
  assign bus.vel_x       = v_x;
  assign bus.vel_y       = v_y;
  assign bus.wall_hit    = wall_hit;
  assign bus.update_done = update_done;
  assign bus.overrun     = overrun;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed and randomized bench for player_motion_ctrl against an integer motion model.
module tb_player_motion_ctrl;
  import player_motion_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  player_motion_ctrl_if bus();
  player_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.update_done === 1'b1) pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: positions in sixteenths of a pixel, velocities in sixteenths per frame.
  int        mx, my, mvx, mvy;
  logic      m_over;
  logic [3:0] m_hit;

  task automatic model_reset();
    mx = HOME_X * 16; my = HOME_Y * 16; mvx = 0; mvy = 0; m_over = 1'b0; m_hit = 4'd0;
  endtask

  task automatic model_axis(inout int p, inout int v, input int tilt, input int lim,
                            output logic lo, output logic hi);
    int acc, nv;
    acc = (tilt >= 0) ? tilt / 4 : -((-tilt + 3) / 4);   // floor(tilt/4)
    nv  = v + acc - v / 16;                              // drag truncates toward zero
    if (nv > VMAX)  nv = VMAX;
    if (nv < -VMAX) nv = -VMAX;
    p  = p + nv;
    lo = (p < RADIUS * 16);
    hi = !lo && (p / 16 > lim);
    if (lo) begin p = RADIUS * 16; nv = -(nv / 2); end
    if (hi) begin p = lim * 16;    nv = -(nv / 2); end
    v = nv;
  endtask

  task automatic model_tick(input int tx, input int ty);
    logic lx, hx, ly, hy;
    model_axis(mx, mvx, tx, H_ACTIVE - 1 - RADIUS, lx, hx);
    model_axis(my, mvy, ty, V_ACTIVE - 1 - RADIUS, ly, hy);
    m_hit = {hy, ly, hx, lx};
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".position_x"}, bus.position_x, mx / 16);
    check({tag, ".position_y"}, bus.position_y, my / 16);
    check({tag, ".vel_x"}, bus.vel_x, mvx);
    check({tag, ".vel_y"}, bus.vel_y, mvy);
    check({tag, ".wall_hit"}, bus.wall_hit, m_hit);
    check({tag, ".overrun"}, bus.overrun, m_over);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.update_done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called on a falling edge; returns on the falling edge where update_done is seen.
  task automatic do_tick(input string tag, input int tx, input int ty);
    int lat;
    bus.tilt_x     = 8'(tx);
    bus.tilt_y     = 8'(ty);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    wait_done(lat);
    check({tag, ".latency"}, lat, 5);
    model_tick(tx, ty);
    check_outputs(tag);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    model_reset();
  endtask

  task automatic idle_no_pulse(input string tag, input int cycles);
    int base;
    base = pulses;
    repeat (cycles) @(negedge clk);
    check({tag, ".no_update"}, pulses - base, 0);
  endtask

  initial begin
    int base, found;
    bus.frame_tick = 1'b0;
    bus.game_en    = 1'b1;
    bus.restart    = 1'b0;
    bus.tilt_x     = '0;
    bus.tilt_y     = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset.update_done", bus.update_done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Zero tilt: ten commits, nothing moves
    base = pulses;
    repeat (10) do_tick("zero", 0, 0);
    check("zero.pulses", pulses - base, 10);

    // Constant +32 tilt
    do_tick("tilt32a", 32, 0);
    check("tilt32a.vel_x", bus.vel_x, 8);
    do_tick("tilt32b", 32, 0);
    check("tilt32b.vel_x", bus.vel_x, 16);
    check("tilt32b.position_x", bus.position_x, 321);
    @(negedge clk);
    check("pulse_width.update_done", bus.update_done, 0);

    // Velocity saturation both ways
    do_restart();
    repeat (20) begin
      do_tick("satpos", 127, 0);
      check("satpos.bound", (bus.vel_x > 8'sd64) ? 1 : 0, 0);
    end
    check("satpos.final", bus.vel_x, 64);
    do_restart();
    repeat (20) do_tick("satneg", -128, 0);
    check("satneg.final", bus.vel_x, -64);

    // Right wall
    do_restart();
    found = 0;
    for (int i = 0; i < 150 && found == 0; i++) begin
      do_tick("right", 127, 0);
      if (bus.wall_hit != 4'd0) found = 1;
    end
    check("right.found", found, 1);
    check("right.wall_hit", bus.wall_hit, 4'b0010);
    check("right.position_x", bus.position_x, 623);
    check("right.vel_x", bus.vel_x, -32);
    @(negedge clk);
    check("right.pulse_width", bus.wall_hit, 0);

    // Top wall
    do_restart();
    found = 0;
    for (int i = 0; i < 150 && found == 0; i++) begin
      do_tick("top", 0, -128);
      if (bus.wall_hit != 4'd0) found = 1;
    end
    check("top.found", found, 1);
    check("top.wall_hit", bus.wall_hit, 4'b0100);
    check("top.position_y", bus.position_y, 16);
    check("top.vel_y", bus.vel_y, 32);

    // Ticks while disabled are ignored
    do_restart();
    bus.game_en    = 1'b0;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    idle_no_pulse("disabled", 10);
    check_outputs("disabled");
    bus.game_en = 1'b1;

    // Second tick two cycles after the first
    base = pulses;
    bus.tilt_x = 8'sd16; bus.tilt_y = 8'sd16;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (15) @(negedge clk);
    check("overrun.pulses", pulses - base, 1);
    model_tick(16, 16);
    m_hit  = 4'd0;
    m_over = 1'b1;
    check_outputs("overrun");
    do_restart();
    check_outputs("overrun_cleared");

    // game_en falling mid-sequence still completes
    bus.tilt_x = 8'sd40; bus.tilt_y = -8'sd40;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.game_en    = 1'b0;
    begin
      int lat;
      wait_done(lat);
      check("en_fall.latency", lat, 5);
    end
    model_tick(40, -40);
    check_outputs("en_fall");
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    idle_no_pulse("en_low", 10);
    bus.game_en = 1'b1;

    // restart in POS
    repeat (3) do_tick("pre_restart", 60, -60);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    base = pulses;
    do_restart();
    check_outputs("restart_pos");
    check("restart_pos.update_done", bus.update_done, 0);
    idle_no_pulse("restart_pos", 10);
    check("restart_pos.pulses", pulses - base, 0);

    // restart and tick in the same cycle
    do_tick("pre_both", 50, 50);
    bus.frame_tick = 1'b1;
    do_restart();
    bus.frame_tick = 1'b0;
    idle_no_pulse("restart_tick", 10);
    check_outputs("restart_tick");

    // Asynchronous reset while in VEL
    do_tick("pre_rst", 60, 60);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.update_done", bus.update_done, 0);
    @(negedge clk);
    rst = 1'b1;
    idle_no_pulse("async_rst", 10);
    check_outputs("async_rst_after");

    // Randomized tilts, biased toward opposite corners to reach every wall
    for (int i = 0; i < 80; i++)
      do_tick("rand_pp", int'($urandom_range(20, 127)), int'($urandom_range(20, 127)));
    for (int i = 0; i < 80; i++)
      do_tick("rand_nn", -int'($urandom_range(20, 128)), -int'($urandom_range(20, 128)));
    for (int i = 0; i < 60; i++)
      do_tick("rand_any", int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
